// File: rtl/muxs_ctrl.sv
// Operand/write-back mux sequencer: decodes one instruction at a time, drives
// the immediate/operand/write-back selects, issues load reads and pulses the
// register-file write enable.
module muxs_ctrl #(
  parameter int unsigned MemTimeout = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] ir_opcode,
  input  logic [4:0] ir_sub,
  input  logic [4:0] ir_rt,
  input  logic       mem_ack,
  output logic [1:0] mux4to1_select,
  output logic [1:0] imm_reg_select,
  output logic [1:0] write_reg_select,
  output logic       mem_read,
  output logic       reg_write,
  output logic [4:0] wb_addr,
  output logic       illegal,
  output logic       bus_error
);

  localparam int unsigned CntW  = 16;
  localparam int unsigned SelW  = 2;
  localparam int unsigned AddrW = 5;

  localparam logic [CntW-1:0] CntLast = CntW'(MemTimeout - 1);

  localparam logic [5:0] OpAlu  = 6'b100000;
  localparam logic [5:0] OpAddi = 6'b101000;
  localparam logic [5:0] OpOri  = 6'b101100;
  localparam logic [5:0] OpMovi = 6'b100010;
  localparam logic [5:0] OpLwi  = 6'b000010;
  localparam logic [5:0] OpLw   = 6'b011100;

  localparam logic [4:0] SubSlli = 5'b01000;
  localparam logic [4:0] SubSrli = 5'b01001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MEM  = 2'b10,
    WB   = 2'b11
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [CntW-1:0]   r_cnt,       w_cnt_nxt;
  logic [SelW-1:0]   r_mux,       w_mux_nxt;
  logic [SelW-1:0]   r_opr,       w_opr_nxt;
  logic [SelW-1:0]   r_wbs,       w_wbs_nxt;
  logic [AddrW-1:0]  r_wb_addr,   w_wb_addr_nxt;
  logic              r_is_load,   w_is_load_nxt;
  logic              r_illegal,   w_illegal_nxt;
  logic              r_bus_error, w_bus_error_nxt;
  logic              r_mem_read;
  logic              r_reg_write;

  logic              w_legal;
  logic              w_load;
  logic [SelW-1:0]   w_dec_mux;
  logic [SelW-1:0]   w_dec_opr;
  logic [SelW-1:0]   w_dec_wbs;

  // Instruction decode table: selects, load flag and legality
  always_comb begin
    w_legal   = 1'b1;
    w_load    = 1'b0;
    w_dec_mux = 2'b00;
    w_dec_opr = 2'b00;
    w_dec_wbs = 2'b00;
    unique case (ir_opcode)
      OpAlu: begin
        if (ir_sub == SubSlli || ir_sub == SubSrli) begin
          w_dec_opr = 2'b01;
        end
      end
      OpAddi: begin
        w_dec_mux = 2'b01;
        w_dec_opr = 2'b01;
      end
      OpOri: begin
        w_dec_mux = 2'b10;
        w_dec_opr = 2'b01;
      end
      OpMovi: begin
        w_dec_mux = 2'b11;
        w_dec_opr = 2'b01;
        w_dec_wbs = 2'b01;
      end
      OpLwi: begin
        w_dec_opr = 2'b10;
        w_dec_wbs = 2'b10;
        w_load    = 1'b1;
      end
      OpLw: begin
        w_dec_opr = 2'b11;
        w_dec_wbs = 2'b10;
        w_load    = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state and next-register logic; selects hold unless a legal instruction is accepted
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mux_nxt       = r_mux;
    w_opr_nxt       = r_opr;
    w_wbs_nxt       = r_wbs;
    w_wb_addr_nxt   = r_wb_addr;
    w_is_load_nxt   = r_is_load;
    w_illegal_nxt   = 1'b0;
    w_bus_error_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (instr_valid) begin
          if (w_legal) begin
            w_mux_nxt     = w_dec_mux;
            w_opr_nxt     = w_dec_opr;
            w_wbs_nxt     = w_dec_wbs;
            w_wb_addr_nxt = ir_rt;
            w_is_load_nxt = w_load;
            w_state_nxt   = EXEC;
          end else begin
            w_illegal_nxt = 1'b1;
          end
        end
      end
      EXEC: begin
        w_cnt_nxt   = '0;
        w_state_nxt = r_is_load ? MEM : WB;
      end
      MEM: begin
        if (mem_ack) begin
          w_state_nxt = WB;
        end else if (r_cnt == CntLast) begin
          w_bus_error_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      WB: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath-select and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mux       <= '0;
      r_opr       <= '0;
      r_wbs       <= '0;
      r_wb_addr   <= '0;
      r_is_load   <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mux       <= w_mux_nxt;
      r_opr       <= w_opr_nxt;
      r_wbs       <= w_wbs_nxt;
      r_wb_addr   <= w_wb_addr_nxt;
      r_is_load   <= w_is_load_nxt;
      r_illegal   <= w_illegal_nxt;
      r_bus_error <= w_bus_error_nxt;
      r_mem_read  <= (w_state_nxt == MEM);
      r_reg_write <= (w_state_nxt == WB);
    end
  end

  // Ready is decoded from state, masked while reset is held
  assign instr_ready      = (r_state == IDLE) && !rst;
  assign mux4to1_select   = r_mux;
  assign imm_reg_select   = r_opr;
  assign write_reg_select = r_wbs;
  assign wb_addr          = r_wb_addr;
  assign mem_read         = r_mem_read;
  assign reg_write        = r_reg_write;
  assign illegal          = r_illegal;
  assign bus_error        = r_bus_error;

endmodule
